// File: rtl/mem_port_arbiter_pkg.sv
// Purpose : shared types and constants for the memory-port arbiter slice.
// Latency : n/a (types only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

    // Direction encoding of mem_read_or_write.
    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundles the fetch, load/store, memory-port and status signals of the arbiter.
// Latency : n/a (wires only).
// Backpressure: req held by requesters until their done strobe; memory signals completion with mem_finish.
// Modports: slave = arbiter view; master = core requesters plus memory wrapper view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    // Instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    // Load/store requester
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_done;
    // Cache/DDR2 memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read_or_write;
    logic              mem_sig;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_finish;
    // Status
    logic              busy;
    logic [31:0]       cnt_if;
    logic [31:0]       cnt_ls;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_done,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_rdata, ls_done,
        output mem_addr, mem_write_data, mem_read_or_write, mem_sig,
        input  mem_read_data, mem_finish,
        output busy, cnt_if, cnt_ls
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_done,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_rdata, ls_done,
        input  mem_addr, mem_write_data, mem_read_or_write, mem_sig,
        output mem_read_data, mem_finish,
        input  busy, cnt_if, cnt_ls
    );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Purpose : picks the next owner of the memory port and computes the updated starvation count.
// Latency : combinational.
// Backpressure: none; the caller applies the result only when it actually grants.
// Ports: i_if_req/i_ls_req requests, i_starve_cnt current count; o_grant_vld any request,
//        o_owner winner, o_starve_nxt count to store if the grant is taken.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_CONSEC = 4
) (
    input  logic       i_if_req,
    input  logic       i_ls_req,
    input  logic [3:0] i_starve_cnt,
    output logic       o_grant_vld,
    output arb_owner_t o_owner,
    output logic [3:0] o_starve_nxt
);

    localparam logic [3:0] LP_MAX = 4'(MAX_CONSEC);

    logic w_if_wins;

    always_comb begin
        o_grant_vld  = i_if_req | i_ls_req;
        o_owner      = OWN_LS;
        o_starve_nxt = i_starve_cnt;

        // Fetch wins when it is alone, or when load/store has used up its run of grants.
        w_if_wins = i_if_req && (!i_ls_req || (i_starve_cnt == LP_MAX));
        if (w_if_wins) begin
            o_owner = OWN_IF;
        end

        if (o_grant_vld) begin
            if (!w_if_wins && i_if_req) begin
                // Load/store overtook a waiting fetch: count it, saturating.
                o_starve_nxt = (i_starve_cnt >= LP_MAX) ? LP_MAX : (i_starve_cnt + 4'd1);
            end else begin
                o_starve_nxt = 4'd0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one word-level cache/DDR2 port between instruction fetch and load/store.
// Latency : request in IDLE at t -> mem_sig at t+1; mem_finish at f -> done at f+1; min 3 cycles/access.
// Backpressure: one access outstanding; the losing requester simply holds req until it is granted.
// Ports: clk/rst (async active-high); bus (slave modport) carries both requesters, the memory port,
//        busy and the completed-grant counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 32,
    parameter int MAX_CONSEC = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    arb_owner_t        w_owner;
    logic              w_grant_vld;
    logic              w_capture;
    logic [3:0]        r_starve_cnt;
    logic [3:0]        w_starve_nxt;

    logic [ADDR_W-1:0] r_cur_addr;
    logic [DATA_W-1:0] r_cur_wdata;
    logic              r_cur_rw;

    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic [31:0]       r_cnt_if;
    logic [31:0]       r_cnt_ls;

    mem_arb_prio #(
        .MAX_CONSEC (MAX_CONSEC)
    ) u_prio (
        .i_if_req     (bus.if_req),
        .i_ls_req     (bus.ls_req),
        .i_starve_cnt (r_starve_cnt),
        .o_grant_vld  (w_grant_vld),
        .o_owner      (w_owner),
        .o_starve_nxt (w_starve_nxt)
    );

    // Next-state logic. mem_finish is only looked at in ISSUE and WAIT, so a stray
    // completion in IDLE/RESP (including one left over from before a reset) is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_finish) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_finish) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch and starvation count: updated only when IDLE takes a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= OWN_IF;
            r_cur_addr   <= '0;
            r_cur_wdata  <= '0;
            r_cur_rw     <= MEM_READ;
            r_starve_cnt <= 4'd0;
        end else if ((r_state == IDLE) && w_grant_vld) begin
            r_owner      <= w_owner;
            r_starve_cnt <= w_starve_nxt;
            if (w_owner == OWN_IF) begin
                r_cur_addr  <= bus.if_addr;
                r_cur_wdata <= '0;
                r_cur_rw    <= MEM_READ;
            end else begin
                r_cur_addr  <= bus.ls_addr;
                r_cur_wdata <= bus.ls_wdata;
                r_cur_rw    <= bus.ls_we ? MEM_WRITE : MEM_READ;
            end
        end
    end

    // Read data return: writes leave the owner's rdata register untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else if (w_capture && (r_cur_rw == MEM_READ)) begin
            if (r_owner == OWN_IF) begin
                r_if_rdata <= bus.mem_read_data;
            end else begin
                r_ls_rdata <= bus.mem_read_data;
            end
        end
    end

    // Completed-grant counters bump as RESP retires; they wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_if <= 32'd0;
            r_cnt_ls <= 32'd0;
        end else if (r_state == RESP) begin
            if (r_owner == OWN_IF) begin
                r_cnt_if <= r_cnt_if + 32'd1;
            end else begin
                r_cnt_ls <= r_cnt_ls + 32'd1;
            end
        end
    end

    assign bus.mem_addr          = r_cur_addr;
    assign bus.mem_write_data    = r_cur_wdata;
    assign bus.mem_read_or_write = r_cur_rw;
    assign bus.mem_sig           = (r_state == ISSUE);
    assign bus.if_done           = (r_state == RESP) && (r_owner == OWN_IF);
    assign bus.ls_done           = (r_state == RESP) && (r_owner == OWN_LS);
    assign bus.if_rdata          = r_if_rdata;
    assign bus.ls_rdata          = r_ls_rdata;
    assign bus.busy              = (r_state != IDLE);
    assign bus.cnt_if            = r_cnt_if;
    assign bus.cnt_ls            = r_cnt_ls;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single word-level cache/DDR2 memory port (27-bit address, 32-bit data, `memory_sig` start strobe, `finish` completion strobe) between the core's instruction-fetch requester and its load/store requester. It latches one request at a time, drives the memory port, waits for completion, and returns read data plus a one-cycle done strobe to the granted requester. Data accesses have priority, and a bounded-starvation rule guarantees fetch progress. The block sits in the `cpu_clk` domain between the core and the cache memory wrapper.

## Interface
Parameters:
- `ADDR_W`, 27: memory word-address width.
- `DATA_W`, 32: data width.
- `MAX_CONSEC`, 4: maximum consecutive load/store grants while fetch is waiting (range 1..15).

Ports:
- `clk`  in  1  core clock (`cpu_clk` domain); the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request, held until `if_done`.
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req` is high.
- `if_rdata`  out  DATA_W  fetch read data, valid while `if_done` is high.
- `if_done`  out  1  one-cycle completion strobe.
- `ls_req`  in  1  load/store request, held until `ls_done`.
- `ls_we`  in  1  1 = write, 0 = read.
- `ls_addr`  in  ADDR_W  load/store address.
- `ls_wdata`  in  DATA_W  store data.
- `ls_rdata`  out  DATA_W  load data, valid while `ls_done` is high.
- `ls_done`  out  1  one-cycle completion strobe.
- `mem_addr`  out  ADDR_W  address to the cache port.
- `mem_write_data`  out  DATA_W  write data to the cache port.
- `mem_read_or_write`  out  1  1 = read, 0 = write.
- `mem_sig`  out  1  one-cycle start strobe.
- `mem_read_data`  in  DATA_W  read data from the cache port, valid with `mem_finish`.
- `mem_finish`  in  1  one-cycle completion strobe.
- `busy`  out  1  high in any state other than IDLE.
- `cnt_if`, `cnt_ls`  out  32 each  completed-grant counters; wrap modulo 2^32.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: when either request is high, choose a winner, latch its address, data and direction into the `cur_*` registers, record the owner, and move to ISSUE. With no request, stay in IDLE.
- Priority: `ls` wins unless `if_req` is high and `starve_cnt == MAX_CONSEC`, in which case `if` wins.
- `starve_cnt` (4-bit):
  - increments on an `ls` grant while `if_req` is high;
  - clears on any `if` grant, and on an `ls` grant while `if_req` is low;
  - saturates at MAX_CONSEC.
- Fetch requests are always reads (`mem_read_or_write` = 1).
- ISSUE: `mem_sig` = 1 for exactly this cycle; go to WAIT. If `mem_finish` is already high in ISSUE, go directly to RESP.
- WAIT: hold the `mem_*` outputs; on `mem_finish`, capture `mem_read_data` into the owner's rdata register (writes capture nothing) and go to RESP.
- RESP: the owner's done = 1 for one cycle; increment the owner's counter; go to IDLE.
- `mem_addr`, `mem_write_data` and `mem_read_or_write` are driven from the `cur_*` registers and stay stable from ISSUE through RESP.
- `mem_finish` in IDLE or RESP is ignored and causes no done strobe.
- Requesters drop or replace `req` in the cycle after done. IDLE never re-samples a request that was just completed.

## Timing
- Reset values: state IDLE; `mem_sig`, `if_done`, `ls_done`, `busy` = 0; `mem_read_or_write` = 1; all addr/data outputs 0; counters 0; `starve_cnt` 0.
- Request seen high in IDLE at cycle t: `mem_sig` at t+1. If `mem_finish` arrives at cycle f ≥ t+1: done at f+1, next grant decision at f+2.
- Minimum occupancy is 3 cycles per access. Overhead is 2 cycles beyond memory latency.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. The outstanding memory operation is abandoned, and its late `mem_finish` is ignored.
- Both requests high in IDLE: the grant follows the priority rule above. The loser's request stays pending; no done strobe is lost.

## Structure
- `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, RESP};
  - `arb_owner_t` enum {OWN_IF, OWN_LS};
  - `MEM_READ = 1'b1`, `MEM_WRITE = 1'b0`.
- Sub-module `mem_arb_prio`: combinational winner selection plus the `starve_cnt` update, parameterised by MAX_CONSEC. The top-level module holds the FSM, the latches and the counters.

## Test plan
- Single fetch: `if_addr` = 0x0000100, memory returns 0xDEADBEEF after 5 cycles -> `mem_sig` one cycle after req, `mem_read_or_write` = 1, `if_done` with `if_rdata` = 0xDEADBEEF one cycle after finish, `cnt_if` = 1.
- Store: `ls_we` = 1, `ls_addr` = 0x7FFFFFF, `ls_wdata` = 0x12345678 -> `mem_read_or_write` = 0, `mem_write_data` = 0x12345678 held through WAIT, `ls_done` pulses, `ls_rdata` unchanged.
- Both requesting continuously, MAX_CONSEC = 4 -> grant order ls, ls, ls, ls, if, ls, ls, ls, ls, if…; never more than 4 ls grants between fetch grants.
- `mem_finish` in the ISSUE cycle (zero-latency memory) -> RESP next cycle; spurious `mem_finish` in IDLE -> no done strobe, counters unchanged.
- `rst` asserted in WAIT, then `mem_finish` arrives after release -> outputs at reset values, no done strobe, next request issues normally.
- Run 2^32 − 1 preloaded counter value (force) plus one `ls` grant -> `cnt_ls` wraps to 0.
